// File: rtl/fp_pkg.sv
// Shared types and constants for the pipelined FP accumulation sequencer.
package fp_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    REDUCE
  } state_e;

endpackage

// File: rtl/fp_issue_tracker.sv
// Tracks which adder pipeline slots hold a live partial sum and how many are in flight.
module fp_issue_tracker #(
  parameter int LAT = 7,
  parameter int PW  = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          shift_in,
  output logic          ret_v,
  output logic [PW-1:0] inflight
);

  logic [LAT-1:0] vld_sr_q, vld_sr_d;

  assign vld_sr_d = {vld_sr_q[LAT-2:0], shift_in};
  assign ret_v    = vld_sr_q[LAT-1];

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) vld_sr_q <= '0;
    else       vld_sr_q <= vld_sr_d;
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + PW'(vld_sr_q[i]);
  end

endmodule

// File: rtl/fp_accum_sched.sv
// Streams `count` FP32 values into a shared fixed-latency adder, one partial per
// pipeline stage, then folds the in-flight partials pairwise into a single sum.
module fp_accum_sched
  import fp_pkg::*;
#(
  parameter int ADD_LAT = 7,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  input  logic [FP_W-1:0]  in_data,
  output logic             in_ready,
  output logic [FP_W-1:0]  add_dataa,
  output logic [FP_W-1:0]  add_datab,
  input  logic [FP_W-1:0]  add_result,
  output logic             busy,
  output logic             done,
  output logic [FP_W-1:0]  sum
);

  localparam int PW = $clog2(ADD_LAT + 1);
  localparam logic [PW-1:0] LAT_P = PW'(ADD_LAT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] accepted_q, accepted_d;
  logic [PW-1:0]    partials_q, partials_d;
  logic [FP_W-1:0]  held_q, held_d;
  logic [FP_W-1:0]  sum_q, sum_d;
  logic             held_v_q, held_v_d;
  logic             done_q, done_d;

  logic             issue;
  logic             ret_v;
  logic [PW-1:0]    inflight;
  logic [FP_W-1:0]  ret;

  fp_issue_tracker #(
    .LAT(ADD_LAT),
    .PW (PW)
  ) u_tracker (
    .clk     (clk),
    .reset   (reset),
    .shift_in(issue),
    .ret_v   (ret_v),
    .inflight(inflight)
  );

  // Results in slots not marked live are stale and must never be consumed.
  assign ret  = ret_v ? add_result : FP_ZERO;
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign sum  = sum_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches are inferred.
    state_d    = state_q;
    count_d    = count_q;
    accepted_d = accepted_q;
    partials_d = partials_q;
    held_d     = held_q;
    held_v_d   = held_v_q;
    sum_d      = sum_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    in_ready   = 1'b0;
    add_dataa  = FP_ZERO;
    add_datab  = FP_ZERO;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_d    = ACCUM;
            count_d    = count;
            accepted_d = '0;
            partials_d = '0;
          end else begin
            sum_d  = FP_ZERO;
            done_d = 1'b1;
          end
        end
      end

      ACCUM: begin
        // Each stage carries its own partial; a bubble just adds +0.0.
        in_ready   = 1'b1;
        issue      = 1'b1;
        add_dataa  = ret;
        add_datab  = in_valid ? in_data : FP_ZERO;
        partials_d = (partials_q == LAT_P) ? LAT_P : partials_q + 1'b1;
        if (in_valid) begin
          accepted_d = accepted_q + 1'b1;
          if (accepted_q == count_q - 1'b1) state_d = REDUCE;
        end
      end

      REDUCE: begin
        if (ret_v) begin
          if (held_v_q) begin
            issue      = 1'b1;
            add_dataa  = held_q;
            add_datab  = add_result;
            held_v_d   = 1'b0;
            partials_d = partials_q - 1'b1;
          end else if (partials_q == PW'(1)) begin
            sum_d      = add_result;
            done_d     = 1'b1;
            partials_d = '0;
            state_d    = IDLE;
          end else begin
            held_d   = add_result;
            held_v_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      accepted_q <= '0;
      partials_q <= '0;
      held_q     <= FP_ZERO;
      held_v_q   <= 1'b0;
      sum_q      <= FP_ZERO;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      accepted_q <= accepted_d;
      partials_q <= partials_d;
      held_q     <= held_d;
      held_v_q   <= held_v_d;
      sum_q      <= sum_d;
      done_q     <= done_d;
    end
  end

  // Every live partial is either in the adder or parked in the holding register.
  a_partials_consistent : assert property (@(posedge clk) disable iff (reset)
    partials_q == inflight + PW'(held_v_q));

endmodule

// File: tb/tb_fp_accum_sched.sv
// Randomized scoreboard bench for fp_accum_sched with a behavioural FP adder pipeline.
module tb_fp_accum_sched;

  localparam int ADD_LAT = 7;
  localparam int CNT_W   = 16;
  localparam logic [31:0] JUNK = 32'h40A00000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic [31:0]      add_dataa, add_datab, add_result;
  logic             busy, done;
  logic [31:0]      sum;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] vals[$];
  logic [31:0] pipe[ADD_LAT];

  fp_accum_sched #(.ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .count     (count),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .add_dataa (add_dataa),
    .add_datab (add_datab),
    .add_result(add_result),
    .busy      (busy),
    .done      (done),
    .sum       (sum)
  );

  always #5 clk = ~clk;

  function automatic real to_real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'h0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] from_real(input real r);
    logic [63:0] b;
    int e;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic logic [31:0] int_to_fp(input int v);
    return from_real(real'(v));
  endfunction

  // Adder: operands sampled at an edge appear ADD_LAT edges later.
  initial for (int i = 0; i < ADD_LAT; i++) pipe[i] = 32'h42F60000;
  always @(posedge clk) begin
    pipe[0] <= from_real(to_real(add_dataa) + to_real(add_datab));
    for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign add_result = pipe[ADD_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_sum();
    real acc = 0.0;
    foreach (vals[i]) acc += to_real(vals[i]);
    return from_real(acc);
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got sum %h want no done", sum);
      end else begin
        check("sum", sum, exp_q.pop_front());
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // mode: 0 = always valid, 1 = alternate valid/bubble, 2 = random bubbles.
  // glitch_at >= 0 pulses start with a different count at that feed cycle and again in REDUCE.
  task automatic run_sum(input int mode, input int glitch_at);
    int n, idx, cyc, t;
    logic v;
    n = vals.size();
    @(negedge clk);
    start = 1'b1;
    count = CNT_W'(n);
    exp_q.push_back(ref_sum());
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      check("zero_count_done", 32'(done), 32'd1);
    end else begin
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 4 * n + 20) begin
        case (mode)
          0:       v = 1'b1;
          1:       v = (cyc % 2 == 0);
          default: v = ($urandom_range(0, 3) != 0);
        endcase
        in_valid = v;
        in_data  = v ? vals[idx] : JUNK;
        start    = (cyc == glitch_at);
        count    = CNT_W'(n + 3);
        if (v && in_ready) idx++;
        @(negedge clk);
        cyc++;
      end
      if (idx < n) begin
        total++;
        bad++;
        $display("FAIL feed_timeout: got %0d accepted want %0d", idx, n);
      end
      in_valid = 1'b0;
      in_data  = JUNK;
      start    = (glitch_at >= 0);
      check("in_ready_after_last", 32'(in_ready), 32'd0);
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_sum"}, sum, 32'h0);
    check({tag, "_dataa"}, add_dataa, 32'h0);
    check({tag, "_datab"}, add_datab, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    count    = '0;
    in_valid = 1'b0;
    in_data  = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    vals = {32'h3F800000};
    run_sum(0, -1);

    vals.delete();
    repeat (10) vals.push_back(32'h4640E400);
    run_sum(0, -1);

    vals = {32'h3F800000, 32'h3F800000, 32'h3F800000};
    run_sum(1, -1);

    vals = {32'h3FC00000, 32'hBFC00000, 32'h40000000, 32'hC0000000};
    run_sum(0, -1);

    vals.delete();
    run_sum(0, -1);

    vals.delete();
    for (int i = 0; i < 6; i++) vals.push_back(int_to_fp($urandom_range(1, 50)));
    run_sum(0, 2);

    for (int t = 0; t < 8; t++) begin
      vals.delete();
      for (int i = 0; i < int'($urandom_range(1, 24)); i++)
        vals.push_back(int_to_fp(int'($urandom_range(0, 200)) - 100));
      run_sum(2, -1);
    end

    // Abort a sum mid-ACCUM after 5 of 8 elements.
    @(negedge clk);
    start = 1'b1;
    count = CNT_W'(8);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = int_to_fp(i + 7);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("abort");
    repeat (ADD_LAT + 4) @(negedge clk);

    vals = {32'h3F800000, 32'h3F800000};
    run_sum(0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_accum_sched.md
Name: fp_accum_sched

Overview:
- Sequencer that shares one external pipelined FP adder (altfp_add, fixed latency) to sum a stream of `count` single-precision values.
- During accumulation, every adder pipeline stage carries an independent partial sum, so one input is accepted per cycle with no feedback hazard.
- After the last input, the in-flight partials are reduced pairwise through the same adder and the final sum is reported with a done pulse.
- Sits between the data source and the accumulator adder in the Black-Scholes processor.

Parameters:
- ADD_LAT, 7: adder latency in cycles. Operands sampled at edge t are valid on add_result after edge t+ADD_LAT. Must be >= 2.
- CNT_W, 16: width of the element count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a new sum; sampled only in IDLE
- count  in  CNT_W  number of elements; sampled with start
- in_valid  in  1  source has in_data
- in_data  in  32  IEEE-754 single element
- in_ready  out  1  element accepted when in_valid && in_ready
- add_dataa  out  32  adder operand A (driven combinationally from registered state)
- add_datab  out  32  adder operand B
- add_result  in  32  adder output
- busy  out  1  high from ACCUM through REDUCE
- done  out  1  one-cycle pulse when sum is valid
- sum  out  32  final result; held until the next start

Behaviour:
- Reset:
  - in_ready=0, busy=0, done=0, sum=0.
  - add_dataa and add_datab = 0.
  - Issue-valid shift register vld_sr[ADD_LAT-1:0] cleared; held_v=0; state=IDLE.
  - Reset mid-operation abandons the sum; results still in the adder are ignored because vld_sr is cleared.
- Returning operand: ret_v = vld_sr[ADD_LAT-1]. ret = ret_v ? add_result : 32'h0.
- IDLE:
  - start && count!=0 -> ACCUM; accepted<=0, partials<=0.
  - start && count==0 -> done=1 the next cycle with sum=0; stay IDLE.
  - start is ignored in all other states.
- ACCUM:
  - in_ready=1.
  - Every cycle issue add_dataa=ret, add_datab=(in_valid ? in_data : 0), and shift 1 into vld_sr. A bubble therefore adds +0.0.
  - partials increments each cycle, saturating at ADD_LAT.
  - On acceptance, accepted++. When the accepted element is the count-th: in_ready=0 from the next cycle, and go to REDUCE with partials = min(partials+1, ADD_LAT).
- REDUCE: in_ready=0. Per cycle:
  - ret_v && held_v: issue add(held, add_result); shift 1 into vld_sr; held_v<=0; partials--.
  - ret_v && !held_v && partials==1: sum<=add_result; done pulse; -> IDLE.
  - ret_v && !held_v && partials>1: held<=add_result; held_v<=1; shift 0 into vld_sr.
  - !ret_v: shift 0 into vld_sr; operands 0.
- Invariant: partials = (number of set vld_sr bits) + held_v.
- Latency: for count=N with no bubbles, done follows the last acceptance by between ADD_LAT+1 and about (ceil(log2 ADD_LAT)+1)*ADD_LAT+ADD_LAT cycles. The bench checks the value, not the exact cycle.
- Summation order differs from a sequential sum, so rounding may differ. Tests use exactly representable values.
- in_data presented while in_ready=0 is not consumed.

Decomposition:
- Shared package fp_pkg:
  - FP_W=32.
  - FP_ZERO=32'h0.
  - State enum IDLE/ACCUM/REDUCE.
- Sub-module fp_issue_tracker:
  - ADD_LAT-deep valid shift register.
  - Outputs ret_v and the in-flight population count.
- Everything else stays in one module.

Test Plan:
- start, count=1, in_data 0x3F800000 (1.0) -> done pulse once, sum=0x3F800000, busy low after done.
- count=10 of 0x4640E400 (12345.0), in_valid held high -> sum=0x47F11D00 (123450.0), in_ready low after the 10th acceptance.
- count=3 (< ADD_LAT) of 1.0 with in_valid toggling 1,0,1,0,1 -> sum=0x40400000 (3.0); bubbles do not advance accepted.
- count=4: 1.5, -1.5, 2.0, -2.0 -> sum=0x00000000. Then start with count=0 -> done next cycle, sum=0.
- reset asserted for 1 cycle mid-ACCUM after 5 of 8 elements -> all outputs at reset values. A new start with count=2 of 1.0 -> sum=0x40000000 and no stale partials.
- start pulsed while busy with a different count -> ignored; the original sum completes with the original count.
